// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO and handshake sequencer feeding the UART transmitter.
// The system side writes bytes at up to one per clock. The sequencer offers
// one byte at a time on tx_data/tx_ready and waits for tx_done before popping.

module uart_tx_fifo #(
  parameter int WORDSIZE = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [WORDSIZE-1:0] wr_data,
  output logic                full,
  output logic                empty,
  output logic [ADDR_W:0]     count,
  output logic                overflow,
  output logic [WORDSIZE-1:0] tx_data,
  output logic                tx_ready,
  input  logic                tx_done,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    POP  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  state_t              state;
  state_t              state_next;
  logic [WORDSIZE-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                pop;
  logic                wr_accept;
  logic                wr_drop;
  logic                load;

  // The pop in the POP state frees a slot in the same cycle, so a write that
  // arrives while full is still accepted when it coincides with a pop.
  assign pop       = (state == POP);
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign wr_accept = wr_en && (!full || pop);
  assign wr_drop   = wr_en && full && !pop;
  assign load      = (state == IDLE) && !empty;
  assign tx_ready  = (state == SEND);
  assign busy      = (state != IDLE);

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer advances on every accepted byte and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances once per delivered byte, in the POP state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy counter kept apart from the pointers so 0 and DEPTH differ.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_accept, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag recording that at least one byte was dropped since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end
  end

  // Output byte is captured on leaving IDLE and held through SEND and POP.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= '0;
    end else if (load) begin
      tx_data <= mem[rd_ptr];
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: offer a byte, hold until tx_done, then spend one cycle
  // with tx_ready low so the transmitter cannot resend the same byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_done) begin
          state_next = POP;
        end
      end
      POP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo. A reference model tracks
// FIFO occupancy and the expected byte order; a transmitter model answers
// tx_ready with tx_done; a monitor checks every byte the DUT offers.

module tb_uart_tx_fifo;

  localparam int WORDSIZE = 8;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wr_en = 1'b0;
  logic [WORDSIZE-1:0] wr_data = '0;
  logic                full;
  logic                empty;
  logic [ADDR_W:0]     count;
  logic                overflow;
  logic [WORDSIZE-1:0] tx_data;
  logic                tx_ready;
  logic                tx_done = 1'b0;
  logic                busy;

  int tests = 0;
  int fails = 0;

  logic [WORDSIZE-1:0] exp_q[$];
  int   occ = 0;
  bit   exp_ovf = 1'b0;
  bit   pop_pending = 1'b0;
  bit   rst_pending = 1'b0;
  bit   armed = 1'b0;
  int   pushed = 0;

  int   delivered = 0;
  logic [WORDSIZE-1:0] last_byte = '0;
  bit   prev_hs = 1'b0;

  bit   stall = 1'b0;
  bit   spurious = 1'b0;
  int   fixed_lat = 10;
  int   wait_cnt = 0;
  int   target = 10;

  uart_tx_fifo #(
    .WORDSIZE(WORDSIZE),
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .busy(busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of write-side inputs, sampled by the following clock edge.
  task automatic applyStimulus(input logic we, input logic [WORDSIZE-1:0] d);
    @(posedge clk);
    #1;
    wr_en   = we;
    wr_data = d;
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst   = 1'b1;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && !tx_ready && count == '0) done = 1'b1;
    end
    checkOutput("drain within budget", 32'(done), 32'd1);
  endtask

  // Reference model: occupancy arithmetic and expected byte order. At each
  // falling edge it first compares status with the model, then predicts the
  // effect of the coming rising edge. A byte handed over at edge H is freed
  // at edge H+1, which is when a write into a full FIFO can again be taken.
  always @(negedge clk) begin
    if (rst) begin
      rst_pending = 1'b1;
      pop_pending = 1'b0;
    end else begin
      if (rst_pending) begin
        exp_q.delete();
        occ         = 0;
        exp_ovf     = 1'b0;
        rst_pending = 1'b0;
        armed       = 1'b1;
        checkOutput("tx_ready after reset", 32'(tx_ready), 32'd0);
        checkOutput("busy after reset", 32'(busy), 32'd0);
        checkOutput("tx_data after reset", 32'(tx_data), 32'd0);
      end
      if (armed) begin
        bit acc;
        bit hs;
        checkOutput("count", 32'(count), 32'(occ));
        checkOutput("empty", 32'(empty), 32'(occ == 0));
        checkOutput("full", 32'(full), 32'(occ == DEPTH));
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
        hs  = (tx_ready === 1'b1) && (tx_done === 1'b1);
        acc = wr_en && ((occ < DEPTH) || pop_pending);
        if (acc) begin
          exp_q.push_back(wr_data);
          pushed++;
        end
        if (wr_en && !acc) exp_ovf = 1'b1;
        occ = occ + int'(acc) - int'(pop_pending);
        pop_pending = hs;
      end
    end
  end

  // Transmitter model: after tx_ready has been seen for 'target' cycles it
  // pulses tx_done once; a stall holds it off and 'spurious' forces a pulse.
  always begin
    @(posedge clk);
    #2;
    if (spurious) begin
      tx_done = 1'b1;
    end else if (tx_done || rst || stall || tx_ready !== 1'b1) begin
      tx_done  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= target) begin
      tx_done  = 1'b1;
      wait_cnt = 0;
      target   = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
    end else begin
      wait_cnt++;
    end
  end

  // Monitor: every cycle tx_ready is high the offered byte must be the oldest
  // expected byte; a handshake retires it; tx_ready must drop right after.
  always @(negedge clk) begin
    if (rst) begin
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) checkOutput("tx_ready low in pop cycle", 32'(tx_ready), 32'd0);
      if (tx_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("tx_ready with nothing queued", 32'(tx_ready), 32'd0);
        end else begin
          checkOutput("tx_data", 32'(tx_data), 32'(exp_q[0]));
        end
      end
      prev_hs = (tx_ready === 1'b1) && (tx_done === 1'b1);
      if (prev_hs && exp_q.size() > 0) begin
        last_byte = exp_q.pop_front();
        delivered++;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    int  d0;
    int  p0;
    bit  found;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset empty", 32'(empty), 32'd1);
    checkOutput("reset count", 32'(count), 32'd0);

    // Single byte with a 10-cycle transmitter
    fixed_lat = 10;
    target    = 10;
    d0 = delivered;
    applyStimulus(1'b1, 8'h41);
    applyStimulus(1'b0, 8'h00);
    @(negedge clk);
    checkOutput("t1 ready low after write edge", 32'(tx_ready), 32'd0);
    @(negedge clk);
    checkOutput("t1 ready high two cycles after write", 32'(tx_ready), 32'd1);
    checkOutput("t1 tx_data", 32'(tx_data), 32'h41);
    waitIdle(200);
    checkOutput("t1 delivered", 32'(delivered - d0), 32'd1);
    checkOutput("t1 empty", 32'(empty), 32'd1);
    checkOutput("t1 busy", 32'(busy), 32'd0);

    // Burst of five
    fixed_lat = 4;
    d0 = delivered;
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i));
    applyStimulus(1'b0, 8'h00);
    @(negedge clk);
    checkOutput("t2 count after burst", 32'(count), 32'd5);
    waitIdle(300);
    checkOutput("t2 delivered", 32'(delivered - d0), 32'd5);
    checkOutput("t2 last byte", 32'(last_byte), 32'h05);

    // Overflow with the transmitter stalled
    stall = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(8'h80 + i));
    applyStimulus(1'b0, 8'h00);
    @(negedge clk);
    checkOutput("t3 full", 32'(full), 32'd1);
    checkOutput("t3 count", 32'(count), 32'd16);
    checkOutput("t3 overflow", 32'(overflow), 32'd1);
    #1 stall = 1'b0;
    fixed_lat = 0;
    waitIdle(600);
    checkOutput("t3 delivered", 32'(delivered - d0), 32'd16);
    checkOutput("t3 last byte", 32'(last_byte), 32'h8F);
    checkOutput("t3 overflow sticky", 32'(overflow), 32'd1);

    // Write during the pop of a full FIFO
    stall = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'hC0 + i));
    applyStimulus(1'b0, 8'h00);
    #1 stall = 1'b0;
    fixed_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (tx_ready && tx_done) found = 1'b1;
    end
    checkOutput("t4 handshake seen", 32'(found), 32'd1);
    if (found) begin
      applyStimulus(1'b1, 8'hAA);
      applyStimulus(1'b0, 8'h00);
      @(negedge clk);
      checkOutput("t4 count stays full", 32'(count), 32'd16);
    end
    waitIdle(600);
    checkOutput("t4 delivered", 32'(delivered - d0), 32'd17);
    checkOutput("t4 last byte", 32'(last_byte), 32'hAA);

    // Spurious tx_done while idle
    @(posedge clk);
    #1 spurious = 1'b1;
    @(posedge clk);
    #1 spurious = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("t5 tx_ready stays low", 32'(tx_ready), 32'd0);
      checkOutput("t5 count unchanged", 32'(count), 32'd0);
    end

    // Randomized traffic with random stalls and latencies
    fixed_lat = 0;
    p0 = pushed;
    d0 = delivered;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, 8'($urandom));
      if ($urandom_range(0, 19) == 0) stall = !stall;
    end
    applyStimulus(1'b0, 8'h00);
    #1 stall = 1'b0;
    waitIdle(2000);
    checkOutput("random delivered all accepted", 32'(delivered - d0), 32'(pushed - p0));

    // Reset during SEND with bytes queued
    stall = 1'b1;
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    applyStimulus(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("t6 sending 0x55", 32'(tx_data), 32'h55);
    checkOutput("t6 ready before reset", 32'(tx_ready), 32'd1);
    pulseReset();
    @(negedge clk);
    checkOutput("t6 tx_ready dropped", 32'(tx_ready), 32'd0);
    checkOutput("t6 count cleared", 32'(count), 32'd0);
    checkOutput("t6 empty", 32'(empty), 32'd1);
    checkOutput("t6 overflow cleared", 32'(overflow), 32'd0);
    #1 stall = 1'b0;
    fixed_lat = 5;
    d0 = delivered;
    applyStimulus(1'b1, 8'h66);
    applyStimulus(1'b0, 8'h00);
    waitIdle(200);
    checkOutput("t6 delivered after reset", 32'(delivered - d0), 32'd1);
    checkOutput("t6 last byte", 32'(last_byte), 32'h66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and handshake sequencer directly upstream of the UART transmitter.
- Accepts bytes from the system side at up to one per clock and stores them in a circular FIFO.
- Presents one byte at a time on the transmitter's data_in/ready inputs and waits for its tx_done pulse before advancing.
- Lets ACK/NAK and status producers queue multi-byte responses without tracking baud timing.

Parameters:
- WORDSIZE, 8, width of each stored byte; must match the transmitter's WORDSIZE.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, pointer width; log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; one byte accepted per cycle when not full.
- wr_data  input  WORDSIZE  byte to enqueue.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  occupied entries, 0..DEPTH.
- overflow  output  1  sticky; set when a write arrives while full.
- tx_data  output  WORDSIZE  byte for the transmitter's data_in.
- tx_ready  output  1  drives the transmitter's ready input.
- tx_done  input  1  one-cycle completion pulse from the transmitter.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (synchronous, rst high at posedge) clears all state:
  - rd_ptr = wr_ptr = 0, count = 0, overflow = 0, state = IDLE.
  - tx_data = 0, tx_ready = 0, busy = 0, empty = 1, full = 0.
  - Storage contents are not cleared.
- Write path:
  - wr_en && !full: mem[wr_ptr] <= wr_data, wr_ptr increments mod DEPTH.
  - wr_en && full: write dropped, overflow <= 1. Overflow stays set until rst.
- Pointers wrap from DEPTH-1 to 0. count is a separate counter, so it is unambiguous at 0 and DEPTH.
- Count update per cycle: +1 on accepted write only; -1 on pop only; unchanged when both occur in the same cycle.
  - Simultaneous write and pop while full: the write is accepted, because the pop frees the slot in the same cycle.
- State machine, registered state, 2 bits:
  - IDLE: if !empty, tx_data <= mem[rd_ptr] and go to SEND; otherwise stay.
  - SEND: tx_ready = 1 (combinational from state). tx_data is held constant. Stay until tx_done == 1, then go to POP.
  - POP: tx_ready = 0; rd_ptr increments mod DEPTH; count decrements; go to IDLE.
- Handshake rules:
  - tx_ready is level-held from SEND entry until the cycle tx_done is seen. This covers the transmitter's one-cycle init state after reset and its wait_for_ready sampling.
  - tx_ready is low in the cycle after tx_done (POP). This prevents the transmitter, now back in wait_for_ready, from resending the same byte.
  - tx_data is stable for the entire SEND residency, including the transmitter's latch cycle one clock after ready is sampled.
- Latency and throughput:
  - A write into an empty idle FIFO produces tx_ready two cycles after the write edge: write edge, then IDLE sees !empty, then SEND.
  - Back-to-back bytes: 2 idle cycles (POP, IDLE) between tx_done and the next tx_ready.
- tx_done is ignored outside SEND.
- A byte written during SEND or POP is queued normally. A written byte is never lost unless full.
- Reset mid-transmission discards queued data and drops tx_ready in the cycle after rst. The transmitter shares rst and restarts independently.

Test Plan:
1. Reset, then write 0x41 once; transmitter model pulses tx_done after 10 cycles -> tx_ready rises 2 cycles after the write, tx_data = 0x41 throughout SEND, one byte delivered, empty = 1, busy = 0.
2. Burst-write 0x01..0x05 on consecutive cycles -> count = 5; delivered in order 0x01..0x05; tx_ready low in every POP cycle; count decrements to 0.
3. With the transmitter model stalled (no tx_done), write 17 bytes into DEPTH = 16 -> full = 1 after byte 16, 17th dropped, overflow = 1, count = 16; after releasing, exactly 16 bytes emerge and overflow stays 1.
4. Full FIFO, assert wr_en in the POP cycle with 0xAA -> count stays 16 and 0xAA emerges last; verify pointer wrap past index 15.
5. Spurious tx_done pulse while IDLE/empty -> no pointer or count change, tx_ready remains 0.
6. Assert rst during SEND of 0x55 with 3 bytes queued -> next cycle tx_ready = 0, count = 0, empty = 1, overflow = 0; a subsequent write of 0x66 transmits normally.
